binary_to_gray_counter: RTL and testbench

Registered binary-to-Gray encoding counter, the encode-side counterpart of the team's combinational `gray_to_binary` decoder. It holds an up/down binary count with synchronous load and presents both the binary value and its Gray encoding, each from a flop. The Gray output is glitch-free and changes exactly one bit per step, so it can serve as a clock-domain-crossing pointer source, for example an async FIFO write or read pointer. Downstream logic in another domain decodes it with `gray_to_binary`.

---
 rtl/gray_pkg.sv | 22 ++
 rtl/bin2gray_comb.sv | 13 +
 rtl/gray_to_binary.sv | 13 +
 rtl/binary_to_gray_counter.sv | 93 +++++++++
 tb/tb_binary_to_gray_counter.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the counter, its encoder and the gray_to_binary decoder.
// Functions work on a fixed maximum width; callers zero-extend and truncate to their own width.
package gray_pkg;

    parameter int GRAY_DEF_WIDTH = 4;
    localparam int GRAY_MAX_WIDTH = 32;

    function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above it.
    function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] gray);
        logic [GRAY_MAX_WIDTH-1:0] bin;
        bin[GRAY_MAX_WIDTH-1] = gray[GRAY_MAX_WIDTH-1];
        for (int i = GRAY_MAX_WIDTH-2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/bin2gray_comb.sv
// Purely combinational WIDTH-bit binary-to-Gray encoder.
module bin2gray_comb
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_DEF_WIDTH
) (
    input  logic [WIDTH-1:0] i_bin,
    output logic [WIDTH-1:0] o_gray
);

    assign o_gray = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(i_bin)));

endmodule

// File: rtl/gray_to_binary.sv
// Combinational Gray-to-binary decoder used on the receiving side of a Gray pointer.
module gray_to_binary
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_DEF_WIDTH
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    assign o_bin = WIDTH'(gray2bin(GRAY_MAX_WIDTH'(i_gray)));

endmodule

// File: rtl/binary_to_gray_counter.sv
// Up/down binary counter with synchronous load; binary and Gray values both come from flops,
// so the Gray output is glitch-free and usable as a clock-domain-crossing pointer.
module binary_to_gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_DEF_WIDTH,
    parameter int WRAP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin_q,
    output logic [WIDTH-1:0] gray_q,
    output logic             wrap_p,
    output logic             sat_q
);

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_wrap;
    logic             r_sat;

    logic [WIDTH-1:0] w_bin_step;
    logic             w_at_limit;
    logic [WIDTH-1:0] w_bin_next;
    logic [WIDTH-1:0] w_gray_next;
    logic             w_wrap_next;
    logic             w_sat_next;

    assign w_bin_step = up_dn ? (r_bin + WIDTH'(1)) : (r_bin - WIDTH'(1));
    assign w_at_limit = up_dn ? (r_bin == {WIDTH{1'b1}}) : (r_bin == {WIDTH{1'b0}});

    always_comb begin
        w_bin_next  = r_bin;
        w_wrap_next = 1'b0;
        w_sat_next  = 1'b0;
        if (load) begin
            w_bin_next = load_bin;
        end else if (en) begin
            if (!w_at_limit) begin
                w_bin_next = w_bin_step;
            end else if (WRAP != 0) begin
                w_bin_next  = w_bin_step;
                w_wrap_next = 1'b1;
            end else begin
                w_sat_next = 1'b1;
            end
        end
    end

    // Gray is encoded from the next binary value so both registers always agree.
    bin2gray_comb #(
        .WIDTH (WIDTH)
    ) u_bin2gray (
        .i_bin  (w_bin_next),
        .o_gray (w_gray_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin <= '0;
        end else begin
            r_bin <= w_bin_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gray <= '0;
        end else begin
            r_gray <= w_gray_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrap <= 1'b0;
            r_sat  <= 1'b0;
        end else begin
            r_wrap <= w_wrap_next;
            r_sat  <= w_sat_next;
        end
    end

    assign bin_q  = r_bin;
    assign gray_q = r_gray;
    assign wrap_p = r_wrap;
    assign sat_q  = r_sat;

endmodule

// File: tb/tb_binary_to_gray_counter.sv
// Directed bench for binary_to_gray_counter: a wrapping and a saturating instance share stimulus.
module tb_binary_to_gray_counter;
    import gray_pkg::*;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         up_dn;
    logic         load;
    logic [W-1:0] load_bin;

    logic [W-1:0] w_bin, w_gray, s_bin, s_gray;
    logic         w_wrap, w_sat, s_wrap, s_sat;
    logic [W-1:0] w_dec, s_dec;

    int checks = 0;
    int errors = 0;

    binary_to_gray_counter #(.WIDTH(W), .WRAP(1)) u_wrap (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .load_bin(load_bin),
        .bin_q(w_bin), .gray_q(w_gray), .wrap_p(w_wrap), .sat_q(w_sat)
    );

    binary_to_gray_counter #(.WIDTH(W), .WRAP(0)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .load_bin(load_bin),
        .bin_q(s_bin), .gray_q(s_gray), .wrap_p(s_wrap), .sat_q(s_sat)
    );

    gray_to_binary #(.WIDTH(W)) u_dec_wrap (.i_gray(w_gray), .o_bin(w_dec));
    gray_to_binary #(.WIDTH(W)) u_dec_sat  (.i_gray(s_gray), .o_bin(s_dec));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] gray_tab [16];
        logic [W-1:0] prev_gray;
        logic [W-1:0] exp_bin;
        logic [W-1:0] g;

        gray_tab = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                     4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

        rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_bin = '0;
        step(); step();
        chk("reset_bin", w_bin, 0);
        chk("reset_gray", w_gray, 0);
        chk("reset_wrap", w_wrap, 0);
        chk("reset_sat", s_sat, 0);
        rst_n = 1'b1;

        // Up-count sweep from 0 through the 15 -> 0 wrap.
        en = 1'b1; up_dn = 1'b1;
        prev_gray = w_gray;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk("sweep_gray", w_gray, gray_tab[k-1]);
            chk("sweep_bin", w_bin, k % 16);
            chk("sweep_hamming", $countones(w_gray ^ prev_gray), 1);
            chk("sweep_wrap", w_wrap, (k == 16) ? 1 : 0);
            prev_gray = w_gray;
        end
        chk("sweep_sat_bin", s_bin, 4'hF);
        chk("sweep_sat_flag", s_sat, 1);
        en = 1'b0;
        step();
        chk("wrap_drop", w_wrap, 0);
        chk("idle_hold", w_bin, 0);

        // Asynchronous reset mid-count at 9.
        load = 1'b1; load_bin = 4'h9;
        step();
        chk("load9_bin", w_bin, 4'h9);
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_bin", w_bin, 0);
        chk("async_rst_gray", w_gray, 0);
        chk("async_rst_wrap", w_wrap, 0);
        chk("async_rst_sat_bin", s_bin, 0);
        chk("async_rst_sat", s_sat, 0);
        step();
        chk("rst_held_bin", w_bin, 0);
        rst_n = 1'b1;

        // Down wrap from 0.
        en = 1'b1; up_dn = 1'b0;
        step();
        chk("down_wrap_bin", w_bin, 4'hF);
        chk("down_wrap_gray", w_gray, 4'h8);
        chk("down_wrap_pulse", w_wrap, 1);
        chk("down_sat_bin", s_bin, 0);
        chk("down_sat_flag", s_sat, 1);
        step();
        chk("down_next_bin", w_bin, 4'hE);
        chk("down_next_gray", w_gray, 4'h9);
        chk("down_next_wrap", w_wrap, 0);

        // Load beats enable.
        load = 1'b1; en = 1'b1; up_dn = 1'b1; load_bin = 4'h6;
        step();
        chk("load_pri_bin", w_bin, 4'h6);
        chk("load_pri_gray", w_gray, 4'h5);
        chk("load_pri_wrap", w_wrap, 0);
        load = 1'b0;
        step();
        chk("after_load_bin", w_bin, 4'h7);
        chk("after_load_gray", w_gray, 4'h4);

        // Saturation at the top, release by stepping down, by stepping, and by idling.
        load = 1'b1; load_bin = 4'hF;
        step();
        chk("sat_load_flag", s_sat, 0);
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("sat_hold_bin", s_bin, 4'hF);
            chk("sat_hold_gray", s_gray, 4'h8);
            chk("sat_hold_flag", s_sat, 1);
            chk("sat_no_wrap", s_wrap, 0);
        end
        up_dn = 1'b0;
        step();
        chk("sat_rel_bin", s_bin, 4'hE);
        chk("sat_rel_flag", s_sat, 0);
        up_dn = 1'b1;
        step();
        chk("sat_up_bin", s_bin, 4'hF);
        chk("sat_up_flag", s_sat, 0);
        step();
        chk("sat_again_flag", s_sat, 1);
        en = 1'b0;
        step();
        chk("sat_idle_flag", s_sat, 0);
        chk("sat_idle_bin", s_bin, 4'hF);

        // Saturation at the bottom.
        load = 1'b1; load_bin = 4'h0;
        step();
        load = 1'b0; en = 1'b1; up_dn = 1'b0;
        step();
        chk("sat_min_bin", s_bin, 0);
        chk("sat_min_flag", s_sat, 1);

        // Random round trip against an independent reference count.
        exp_bin = w_bin;
        prev_gray = w_gray;
        for (int k = 0; k < 1000; k++) begin
            en       = 1'($urandom_range(0, 1));
            up_dn    = 1'($urandom_range(0, 1));
            load     = ($urandom_range(0, 15) == 0);
            load_bin = W'($urandom);
            if (load)       exp_bin = load_bin;
            else if (en)    exp_bin = up_dn ? exp_bin + 4'd1 : exp_bin - 4'd1;
            step();
            g = W'(gray2bin(32'(w_gray)));
            chk("rt_model_bin", w_bin, exp_bin);
            chk("rt_dec_wrap", w_dec, w_bin);
            chk("rt_func_wrap", g, w_bin);
            chk("rt_dec_sat", s_dec, s_bin);
            if (!load && en) begin
                chk("rt_hamming", $countones(w_gray ^ prev_gray), 1);
            end
            prev_gray = w_gray;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
